// File: rtl/mem_arbiter.sv
// Sequencing arbiter sharing one combinational data-memory port between fetch and load/store.
// Optional starvation guard for fetch enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int DEPTH      = 256,
  parameter int ADDRW      = $clog2(DEPTH),
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [ADDRW-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [2:0]       d_sel,
  input  logic [ADDRW-1:0] d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_err,
  output logic             mem_write_data,
  output logic             mem_read_data,
  output logic [ADDRW-1:0] mem_addr,
  output logic [2:0]       mem_sel,
  output logic [31:0]      mem_data_in,
  input  logic [31:0]      mem_data_out
);

  localparam int AW1 = ADDRW + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state, state_nx;
  logic             grant_d, grant_if, force_if;
  logic             d_err_now, if_err_now;
  logic             own_if_q, we_q, err_q;
  logic [ADDRW-1:0] addr_q;
  logic [2:0]       sel_q;
  logic [31:0]      wdata_q, if_rdata_q, d_rdata_q;
  logic             mem_we_q, mem_re_q;

  // End address computed one bit wider so accesses near the top never wrap into range.
  function automatic logic range_err(input logic [ADDRW-1:0] addr, input logic [1:0] sz);
    logic [AW1-1:0] n;
    logic [AW1-1:0] last;
    n    = (sz == 2'b00) ? AW1'(1) : (sz == 2'b01) ? AW1'(2) : AW1'(4);
    last = {1'b0, addr} + n;
    return last > AW1'(DEPTH);
  endfunction

  always_comb begin
    d_err_now  = range_err(d_addr, d_sel[1:0])
               || !(d_sel inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               || (d_we && d_sel[2]);
    if_err_now = range_err(if_addr, 2'b10);
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst)                     starve_cnt <= '0;
    else if (!if_req || grant_if) starve_cnt <= '0;
    else if (grant_d)            starve_cnt <= starve_cnt + CW'(1);
  end

  assign force_if = (starve_cnt == CW'(STARVE_MAX));
`else
  // Strict data priority; the comparison only keeps STARVE_MAX referenced.
  assign force_if = (STARVE_MAX < 0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (!rst) begin
          if (d_req && !(force_if && if_req)) grant_d  = 1'b1;
          else if (if_req)                    grant_if = 1'b1;
        end
        state_nx = (grant_d || grant_if) ? ACCESS : IDLE;
      end
      ACCESS:  state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    d_gnt          = grant_d;
    if_gnt         = grant_if;
    d_rvalid       = (state == RESP) && !own_if_q;
    if_rvalid      = (state == RESP) && own_if_q;
    d_err          = d_rvalid && err_q;
    if_err         = if_rvalid && err_q;
    d_rdata        = d_rdata_q;
    if_rdata       = if_rdata_q;
    mem_write_data = mem_we_q;
    mem_read_data  = mem_re_q;
    mem_addr       = addr_q;
    mem_sel        = sel_q;
    mem_data_in    = wdata_q;
  end

  // Enables are flops set on the grant edge, so they are high for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_if_q   <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      if (grant_d) begin
        own_if_q <= 1'b0;
        we_q     <= d_we;
        err_q    <= d_err_now;
        addr_q   <= d_addr;
        sel_q    <= d_sel;
        wdata_q  <= d_wdata;
        mem_we_q <= d_we && !d_err_now;
        mem_re_q <= !d_we && !d_err_now;
      end else if (grant_if) begin
        own_if_q <= 1'b1;
        we_q     <= 1'b0;
        err_q    <= if_err_now;
        addr_q   <= if_addr;
        sel_q    <= 3'b010;
        mem_re_q <= !if_err_now;
      end
      if (state == ACCESS) begin
        if (own_if_q) if_rdata_q <= err_q ? 32'h0 : mem_data_out;
        else          d_rdata_q  <= (we_q || err_q) ? 32'h0 : mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-memory model, response scoreboard, immediate-assert checks.
module tb_mem_arbiter;

  localparam int DEPTH = 256;
  localparam int ADDRW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_req, if_gnt, if_rvalid, if_err;
  logic [ADDRW-1:0] if_addr;
  logic [31:0]      if_rdata;
  logic             d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]       d_sel;
  logic [ADDRW-1:0] d_addr;
  logic [31:0]      d_wdata, d_rdata;
  logic             mem_write_data, mem_read_data;
  logic [ADDRW-1:0] mem_addr;
  logic [2:0]       mem_sel;
  logic [31:0]      mem_data_in, mem_data_out;

  mem_arbiter #(.DEPTH(DEPTH), .ADDRW(ADDRW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory with combinational, size/sign-aware read.
  logic [7:0] mem [DEPTH];

  always @(posedge clk) begin
    if (mem_write_data) begin
      for (int i = 0; i < 4; i++) begin
        if ((mem_sel[1:0] == 2'b10) || (mem_sel[1:0] == 2'b01 && i < 2) || i == 0)
          mem[(int'(mem_addr) + i) % DEPTH] <= mem_data_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    logic [31:0] w;
    w = {mem[(int'(mem_addr) + 3) % DEPTH], mem[(int'(mem_addr) + 2) % DEPTH],
         mem[(int'(mem_addr) + 1) % DEPTH], mem[int'(mem_addr)]};
    case (mem_sel)
      3'b000:  mem_data_out = {{24{w[7]}}, w[7:0]};
      3'b001:  mem_data_out = {{16{w[15]}}, w[15:0]};
      3'b100:  mem_data_out = {24'h0, w[7:0]};
      3'b101:  mem_data_out = {16'h0, w[15:0]};
      default: mem_data_out = w;
    endcase
  end

  typedef struct {
    logic        is_if;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the oldest expectation on every rvalid.
  always @(negedge clk) begin
    if (!rst && (d_rvalid || if_rvalid)) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkb("resp_port", if_rvalid, e.is_if);
        check("resp_rdata", if_rvalid ? if_rdata : d_rdata, e.rdata);
        checkb("resp_err", if_rvalid ? if_err : d_err, e.err);
      end
    end
  end

  logic             s_d_gnt, s_if_gnt, s_d_rvalid, s_if_rvalid, s_mem_we, s_mem_re;
  logic             s_d_err, s_if_err;
  logic [ADDRW-1:0] s_mem_addr;
  logic [2:0]       s_mem_sel;
  logic [31:0]      s_mem_data_in, s_d_rdata, s_if_rdata;
  logic [31:0]      d_exp_rdata, if_exp_rdata;
  logic             d_exp_err, if_exp_err;
  bit               auto_drop = 1'b1;

  // One cycle from posedge+1: sample at negedge, record grants, drop granted requests.
  task automatic run_cycle();
    @(negedge clk);
    s_d_gnt = d_gnt;       s_if_gnt = if_gnt;
    s_d_rvalid = d_rvalid; s_if_rvalid = if_rvalid;
    s_mem_we = mem_write_data; s_mem_re = mem_read_data;
    s_mem_addr = mem_addr; s_mem_sel = mem_sel; s_mem_data_in = mem_data_in;
    s_d_rdata = d_rdata;   s_if_rdata = if_rdata;
    s_d_err = d_err;       s_if_err = if_err;
    if (d_gnt)  sb.push_back('{1'b0, d_exp_rdata, d_exp_err});
    if (if_gnt) sb.push_back('{1'b1, if_exp_rdata, if_exp_err});
    @(posedge clk);
    #1;
    if (auto_drop && s_d_gnt)  d_req = 1'b0;
    if (auto_drop && s_if_gnt) if_req = 1'b0;
  endtask

  task automatic set_d(input logic we, input logic [2:0] sel, input logic [ADDRW-1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    d_we = we; d_sel = sel; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    d_exp_rdata = exp_rdata; d_exp_err = exp_err;
  endtask

  task automatic set_if(input logic [ADDRW-1:0] addr, input logic [31:0] exp_rdata,
                        input logic exp_err);
    if_addr = addr; if_req = 1'b1; if_exp_rdata = exp_rdata; if_exp_err = exp_err;
  endtask

  task automatic wait_d_gnt();
    int n = 1;
    run_cycle();
    while (!s_d_gnt && n < 20) begin run_cycle(); n++; end
    checkb("d_gnt_seen", s_d_gnt, 1'b1);
  endtask

  task automatic wait_if_gnt();
    int n = 1;
    run_cycle();
    while (!s_if_gnt && n < 20) begin run_cycle(); n++; end
    checkb("if_gnt_seen", s_if_gnt, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin run_cycle(); n++; end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic d_op(input logic we, input logic [2:0] sel, input logic [ADDRW-1:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    set_d(we, sel, addr, wdata, exp_rdata, exp_err);
    wait_d_gnt();
    drain();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'h0050_0093;
  end

  initial begin
    int d_cnt;
    int if_cnt;
    int grants;
    int first_if;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_addr = '0; d_wdata = '0;
    d_exp_rdata = '0; d_exp_err = 1'b0; if_exp_rdata = '0; if_exp_err = 1'b0;
    @(posedge clk);
    #1;
    run_cycle();
    run_cycle();
    rst = 1'b0;
    check("reset_outputs",
          32'({s_d_gnt, s_if_gnt, s_d_rvalid, s_if_rvalid, s_mem_we, s_mem_re, s_d_err, s_if_err}),
          32'd0);
    check("reset_mem_addr", 32'(s_mem_addr), 32'd0);
    check("reset_d_rdata", s_d_rdata, 32'd0);

    // Word store, checking the single ACCESS cycle it produces.
    set_d(1'b1, 3'b010, 8'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    wait_d_gnt();
    run_cycle();
    checkb("sw_mem_we", s_mem_we, 1'b1);
    checkb("sw_mem_re", s_mem_re, 1'b0);
    check("sw_mem_addr", 32'(s_mem_addr), 32'h10);
    check("sw_mem_data", s_mem_data_in, 32'hDEAD_BEEF);
    run_cycle();
    checkb("sw_rvalid", s_d_rvalid, 1'b1);
    checkb("sw_mem_we_off", s_mem_we, 1'b0);
    drain();

    d_op(1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    d_op(1'b0, 3'b000, 8'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
    d_op(1'b0, 3'b100, 8'h13, 32'h0, 32'h0000_00DE, 1'b0);
    d_op(1'b0, 3'b001, 8'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
    d_op(1'b0, 3'b101, 8'h11, 32'h0, 32'h0000_ADBE, 1'b0);

    // Fetch: read enable only in the cycle after the grant.
    set_if(8'h20, 32'h0050_0093, 1'b0);
    wait_if_gnt();
    checkb("if_mem_re_T", s_mem_re, 1'b0);
    run_cycle();
    checkb("if_mem_re_T1", s_mem_re, 1'b1);
    check("if_mem_addr", 32'(s_mem_addr), 32'h20);
    check("if_mem_sel", 32'(s_mem_sel), 32'd2);
    run_cycle();
    checkb("if_mem_re_T2", s_mem_re, 1'b0);
    checkb("if_rvalid_T2", s_if_rvalid, 1'b1);
    drain();

    // Simultaneous requests: data first, fetch granted in the data response cycle.
    set_d(1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    set_if(8'h20, 32'h0050_0093, 1'b0);
    run_cycle();
    checkb("both_d_gnt", s_d_gnt, 1'b1);
    checkb("both_if_wait", s_if_gnt, 1'b0);
    run_cycle();
    run_cycle();
    checkb("both_if_gnt", s_if_gnt, 1'b1);
    checkb("both_d_rvalid", s_d_rvalid, 1'b1);
    drain();

    // Range and selector errors, plus legal accesses at the top boundary.
    set_d(1'b0, 3'b010, 8'(DEPTH - 2), 32'h0, 32'h0, 1'b1);
    wait_d_gnt();
    run_cycle();
    checkb("err_no_re", s_mem_re, 1'b0);
    checkb("err_no_we", s_mem_we, 1'b0);
    drain();
    set_d(1'b1, 3'b100, 8'h10, 32'h1234_5678, 32'h0, 1'b1);
    wait_d_gnt();
    run_cycle();
    checkb("err_store_no_we", s_mem_we, 1'b0);
    drain();
    d_op(1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    d_op(1'b0, 3'b011, 8'h10, 32'h0, 32'h0, 1'b1);
    d_op(1'b0, 3'b010, 8'(DEPTH - 4), 32'h0, 32'h0, 1'b0);
    d_op(1'b0, 3'b000, 8'(DEPTH - 1), 32'h0, 32'h0, 1'b0);
    d_op(1'b0, 3'b001, 8'(DEPTH - 1), 32'h0, 32'h0, 1'b1);

    // Both requesters held continuously.
    auto_drop = 1'b0;
    set_d(1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    set_if(8'h20, 32'h0050_0093, 1'b0);
    d_cnt = 0; if_cnt = 0; grants = 0; first_if = -1;
    for (int c = 0; c < 40; c++) begin
      run_cycle();
      if (s_d_gnt) begin d_cnt++; grants++; end
      if (s_if_gnt) begin
        if (first_if < 0) first_if = grants;
        if_cnt++; grants++;
      end
    end
    d_req = 1'b0;
    if_req = 1'b0;
    auto_drop = 1'b1;
    drain();
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_d_cnt", 32'(d_cnt), 32'd16);
    check("starve_if_cnt", 32'(if_cnt), 32'd4);
    check("starve_first_if", 32'(first_if), 32'd4);
`else
    check("starve_d_cnt", 32'(d_cnt), 32'd20);
    check("starve_if_cnt", 32'(if_cnt), 32'd0);
`endif
    check("if_rdata_hold", s_if_rdata, 32'h0050_0093);

    // Reset during the ACCESS cycle of a store.
    set_d(1'b1, 3'b010, 8'h40, 32'h1234_5678, 32'h0, 1'b0);
    wait_d_gnt();
    rst = 1'b1;
    run_cycle();
    checkb("rst_access_we", s_mem_we, 1'b1);
    rst = 1'b0;
    sb.delete();
    run_cycle();
    check("rst_flags",
          32'({s_d_gnt, s_if_gnt, s_d_rvalid, s_if_rvalid, s_mem_we, s_mem_re, s_d_err, s_if_err}),
          32'd0);
    check("rst_mem_addr", 32'(s_mem_addr), 32'd0);
    check("rst_mem_data_in", s_mem_data_in, 32'd0);
    check("rst_rdata", s_d_rdata | s_if_rdata, 32'd0);
    set_d(1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    run_cycle();
    checkb("rst_idle_gnt", s_d_gnt, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing arbiter in front of the byte-addressed data memory. It shares the memory's single combinational access port between the instruction-fetch requester and the load/store requester. Each access runs through a registered IDLE→ACCESS→RESP sequence, so the memory's level-sensitive write/read enables are driven only from flops. It also range-checks every access and flags size/selector errors before the memory is touched.

## Interface
Parameters:
- DEPTH, 256, memory size in bytes
- ADDRW, $clog2(DEPTH), byte-address width
- STARVE_MAX, 4, max consecutive data grants while fetch waits (guard builds only)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDRW  fetch byte address (always a word read)
- if_gnt  out  1  one-cycle pulse; request accepted
- if_rvalid  out  1  one-cycle pulse; if_rdata/if_err valid
- if_rdata  out  32  fetched word
- if_err  out  1  fetch rejected (range)
- d_req  in  1  load/store request; held with fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_sel  in  3  size/sign code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- d_addr  in  ADDRW  byte address
- d_wdata  in  32  store data
- d_gnt  out  1  one-cycle pulse; request accepted
- d_rvalid  out  1  one-cycle pulse; completion for loads and stores
- d_rdata  out  32  load result (0 for stores/errors)
- d_err  out  1  access rejected (range or selector)
- mem_write_data  out  1  memory write enable
- mem_read_data  out  1  memory read enable
- mem_addr  out  ADDRW  memory address
- mem_sel  out  3  memory size/sign code
- mem_data_in  out  32  memory write data
- mem_data_out  in  32  memory read data (combinational)

## Operation
- States: IDLE, ACCESS, RESP. Reset → IDLE.
- Arbitration in IDLE and RESP: if any req, pulse the chosen gnt, latch that request's fields plus owner and err into registers, go to ACCESS; else go to/stay IDLE.
- Priority: data over fetch.
- Size n: sel[1:0] = 00 → 1 byte, 01 → 2 bytes, 10 → 4 bytes. Fetch uses sel = 010 (n = 4).
- Error if addr + n > DEPTH, computed at ADDRW+1 bits with no wrap. Error also on a data d_sel not in {000, 001, 010, 100, 101}, or on a store with d_sel[2] = 1.
- ACCESS: drive mem_addr/mem_sel/mem_data_in from latched registers. Assert mem_write_data (store) or mem_read_data (load/fetch) for exactly this cycle. Both stay 0 when err. Capture mem_data_out into the owner's rdata register at the end of the cycle (0 for store/err). Go to RESP.
- RESP: owner's rvalid = 1 and err = latched err for one cycle; the other port's rvalid = 0.
- mem_* enables are 0 in IDLE and RESP; mem_addr/mem_sel/mem_data_in hold their last values.
- No alignment requirement; misaligned in-range accesses are legal.

## Timing
- Reset: all outputs 0, state IDLE, starve counter 0. Reset asserted during ACCESS deasserts mem enables at that edge; the in-flight access gets no rvalid.
- Latency: req sampled with gnt in cycle T, memory access in T+1, rvalid/rdata/err in T+2.
- Back-to-back: a new grant may occur in the RESP cycle, giving one access per 2 cycles sustained.
- Simultaneous if_req and d_req: d_gnt, unless the starvation guard forces fetch.
- gnt is a pulse. The requester drops or changes req/fields only after gnt; the arbiter ignores field changes after the latch.
- rdata holds its value until the owner's next access completes.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: a counter increments on each d_gnt issued while if_req = 1. It clears on if_gnt or whenever if_req = 0. When the count equals STARVE_MAX, the next arbitration grants fetch even if d_req = 1.
- Undefined: strict data priority; fetch can starve indefinitely; no counter logic present.

## Test plan
- Store then load: d_we=1, sel=010, addr=0x10, wdata=0xDEADBEEF; then a load with sel=010 at 0x10 → d_rdata=0xDEADBEEF at T+2, d_err=0. Then lb at 0x13 → 0xFFFFFFDE; lbu at 0x13 → 0x000000DE.
- Fetch at 0x20 holding 0x00500093 → if_gnt at T, mem_read_data=1 only at T+1, if_rvalid with 0x00500093 at T+2.
- if_req and d_req both held from the same cycle → d_gnt first. The fetch grant follows in the data response cycle, since d_req dropped after d_gnt. Responses arrive 2 cycles apart in grant order.
- Range/selector errors: word load at addr=DEPTH-2 → d_err=1, d_rdata=0, mem enables never asserted. Store with sel=100 → d_err=1, memory unchanged.
- With MEM_ARB_STARVE_GUARD_EN and STARVE_MAX=4: d_req and if_req held continuously → 4 d_gnt, then 1 if_gnt, repeating. Without the macro → if_gnt never.
- rst asserted in ACCESS of a store to 0x40 → no d_rvalid; all outputs 0 on the next cycle; state IDLE.
